// File: rtl/ofdm_symbol_framer.sv
// ofdm_symbol_framer: prepends a sync preamble to each Avalon-ST packet, caps payload length and enforces an idle guard.
// Optional: define OFDM_FRAMER_STATS_EN to add the frame_count / trunc_count outputs.
module ofdm_symbol_framer #(
    parameter int PREAMBLE_LEN = 4,
    parameter int GUARD_LEN = 2,
    parameter int PKT_MAX_LEN = 64
) (
    input  logic        clock_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] asi_in0_data,
    input  logic        asi_in0_valid,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    output logic        asi_in0_ready,
    output logic [31:0] aso_out0_data,
    output logic        aso_out0_valid,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket,
    input  logic        aso_out0_ready
`ifdef OFDM_FRAMER_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] trunc_count
`endif
);
    localparam logic [31:0] PRE_WORD = 32'h8000_0000;
    typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, GUARD} state_t;
    state_t      state;
    logic [7:0]  pre_cnt, guard_cnt;
    logic [15:0] pay_cnt;
    logic        xfer, acc, at_max;
    assign xfer   = aso_out0_valid && aso_out0_ready;
    assign acc    = asi_in0_valid && asi_in0_ready;
    assign at_max = pay_cnt == 16'(PKT_MAX_LEN - 1);
    // A SOP beat is left pending in IDLE; it becomes the first payload word in DATA.
    assign asi_in0_ready = reset_reset_n && (state == IDLE ? asi_in0_valid && !asi_in0_startofpacket :
                                             state == DATA ? !aso_out0_valid || aso_out0_ready :
                                             state == DROP);
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state                  <= IDLE;
            pre_cnt                <= '0;
            guard_cnt              <= '0;
            pay_cnt                <= '0;
            aso_out0_data          <= '0;
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    guard_cnt <= '0;
                    if (asi_in0_valid && asi_in0_startofpacket) begin
                        state   <= PRE;
                        pre_cnt <= '0;
                        pay_cnt <= '0;
                    end
                end
                PRE: begin
                    if (!aso_out0_valid || xfer) begin
                        if (xfer && pre_cnt == 8'(PREAMBLE_LEN - 1)) begin
                            state                  <= DATA;
                            aso_out0_valid         <= 1'b0;
                            aso_out0_startofpacket <= 1'b0;
                        end else begin
                            aso_out0_valid         <= 1'b1;
                            aso_out0_data          <= PRE_WORD;
                            aso_out0_startofpacket <= !aso_out0_valid;
                            pre_cnt                <= pre_cnt + {7'd0, xfer};
                        end
                    end
                end
                DATA: begin
                    if (acc) begin
                        aso_out0_valid         <= 1'b1;
                        aso_out0_data          <= asi_in0_data;
                        aso_out0_startofpacket <= 1'b0;
                        aso_out0_endofpacket   <= asi_in0_endofpacket || at_max;
                        pay_cnt                <= pay_cnt + 16'd1;
                        if (asi_in0_endofpacket) state <= GUARD;
                        else if (at_max) state <= DROP;
                    end else if (xfer) begin
                        aso_out0_valid       <= 1'b0;
                        aso_out0_endofpacket <= 1'b0;
                    end
                end
                DROP: begin
                    if (xfer) begin
                        aso_out0_valid       <= 1'b0;
                        aso_out0_endofpacket <= 1'b0;
                    end
                    // With no guard and the forced-EOP word already gone there is nothing left to wait for.
                    if (acc && asi_in0_endofpacket)
                        state <= (GUARD_LEN == 0 && (!aso_out0_valid || xfer)) ? IDLE : GUARD;
                end
                GUARD: begin
                    if (aso_out0_valid) begin
                        if (xfer) begin
                            aso_out0_valid       <= 1'b0;
                            aso_out0_endofpacket <= 1'b0;
                            if (GUARD_LEN == 0) state <= IDLE;
                        end
                    end else if (guard_cnt == 8'(GUARD_LEN - 1)) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef OFDM_FRAMER_STATS_EN
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_count <= '0;
            trunc_count <= '0;
        end else begin
            if (xfer && aso_out0_endofpacket) frame_count <= frame_count + 16'd1;
            if (state == DATA && acc && !asi_in0_endofpacket && at_max) trunc_count <= trunc_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// tb_ofdm_symbol_framer: table-driven and randomized checks of the framer against a packet-level model.
module tb_ofdm_symbol_framer;
    localparam int PRE = 4, GRD = 2, MAXL = 4;
    typedef struct packed {logic [31:0] d; logic s; logic e;} word_t;
    typedef struct {int n_stray; int len; logic [31:0] base; int mode; int exp_words;} vec_t;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_sop, out_eop, out_ready = 1'b1;
`ifdef OFDM_FRAMER_STATS_EN
    logic [15:0] frame_count, trunc_count;
`endif
    word_t got[$], exp_q[$], prev;
    vec_t  tbl[7];
    int    checks = 0, errors = 0, exp_frames = 0, exp_truncs = 0, mode = 0, cyc = 0;
    bit    prev_stall = 0;

    always #5 clk = ~clk;

    ofdm_symbol_framer #(.PREAMBLE_LEN(PRE), .GUARD_LEN(GRD), .PKT_MAX_LEN(MAXL)) dut (
        .clock_clk(clk), .reset_reset_n(rst_n),
        .asi_in0_data(in_data), .asi_in0_valid(in_valid), .asi_in0_startofpacket(in_sop),
        .asi_in0_endofpacket(in_eop), .asi_in0_ready(in_ready),
        .aso_out0_data(out_data), .aso_out0_valid(out_valid), .aso_out0_startofpacket(out_sop),
        .aso_out0_endofpacket(out_eop),
`ifdef OFDM_FRAMER_STATS_EN
        .frame_count(frame_count), .trunc_count(trunc_count),
`endif
        .aso_out0_ready(out_ready));

    // Downstream ready: always on, the 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        cyc++;
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                checks++;
                if ({out_data, out_sop, out_eop, out_valid} !== {prev, 1'b1}) begin
                    errors++;
                    $display("FAIL stall_hold got %h v=%b want %h v=1", {out_data, out_sop, out_eop}, out_valid, prev);
                end
            end
            if (out_valid && !out_ready && !out_eop) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_stall got %b want 0", in_ready);
                end
            end
            if (out_valid && out_ready) got.push_back({out_data, out_sop, out_eop});
            prev_stall = out_valid && !out_ready;
            prev = {out_data, out_sop, out_eop};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
        int n = 0;
        logic r;
        in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 500);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        checks++;
        if (!r) begin
            errors++;
            $display("FAIL beat_accept d=%h got not accepted want accepted within 500 cycles", d);
        end
    endtask

    // Model: preamble words (SOP on the first), then up to MAXL payload words with EOP on the last kept one.
    task automatic send_pkt(input int n_stray, input int len, input logic [31:0] base, input bit rnd);
        logic [31:0] d;
        logic s;
        int n;
        for (int i = 0; i < n_stray; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick;
            send_beat(rnd ? 32'($urandom) : (base ^ 32'h0F0F_0000) + 32'(i), 1'b0, 1'b0);
        end
        n = len < MAXL ? len : MAXL;
        for (int p = 0; p < PRE; p++) exp_q.push_back({32'h8000_0000, p == 0, 1'b0});
        for (int i = 0; i < len; i++) begin
            d = rnd ? 32'($urandom) : base + 32'(i);
            s = (i == 0) || (rnd && $urandom_range(0, 3) == 0);
            if (i < n) exp_q.push_back({d, 1'b0, i == n - 1});
            if (rnd) repeat ($urandom_range(0, 1)) tick;
            send_beat(d, s, i == len - 1);
        end
        exp_frames++;
        if (len > MAXL) exp_truncs++;
    endtask

    task automatic drain_check(input string tag, input int exp_words);
        int n = 0;
        while (got.size() < exp_q.size() && n < 400) begin
            tick;
            n++;
        end
        repeat (GRD + 4) tick;
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s word_count got %0d want %0d", tag, got.size(), exp_q.size());
        end
        if (exp_words >= 0) begin
            checks++;
            if (got.size() != exp_words) begin
                errors++;
                $display("FAIL %s table_count got %0d want %0d", tag, got.size(), exp_words);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d got %h want %h (data,sop,eop)", tag, i, i < got.size() ? got[i] : '0, exp_q[i]);
            end
        end
`ifdef OFDM_FRAMER_STATS_EN
        checks += 2;
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL %s frame_count got %0d want %0d", tag, frame_count, exp_frames);
        end
        if (trunc_count !== 16'(exp_truncs)) begin
            errors++;
            $display("FAIL %s trunc_count got %0d want %0d", tag, trunc_count, exp_truncs);
        end
`endif
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({out_valid, out_sop, out_eop, out_data, in_ready} !== '0) begin
            errors++;
            $display("FAIL %s reset_outputs got v=%b s=%b e=%b d=%h rdy=%b want all 0",
                     tag, out_valid, out_sop, out_eop, out_data, in_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        int cnt, n;
        bit low_ok;
        tbl[0] = '{0, 3, 32'h0000_00A1, 0, 7};
        tbl[1] = '{0, 1, 32'h1234_5670, 0, 5};
        tbl[2] = '{0, 6, 32'hB000_0000, 0, 8};
        tbl[3] = '{2, 3, 32'hC000_0000, 0, 7};
        tbl[4] = '{0, 4, 32'hD000_0000, 1, 8};
        tbl[5] = '{1, 5, 32'hE000_0000, 1, 8};
        tbl[6] = '{0, 2, 32'hF000_0000, 1, 6};

        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        #2 check_zero("por");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        foreach (tbl[k]) begin
            mode = tbl[k].mode;
            send_pkt(tbl[k].n_stray, tbl[k].len, tbl[k].base, 1'b0);
            drain_check($sformatf("vec%0d", k), tbl[k].exp_words);
        end
        mode = 0;
        tick;

        // Guard length: a non-SOP beat waiting behind the packet is taken only once the guard expires.
        send_pkt(0, 1, 32'h1234_5670, 1'b0);
        in_data = 32'hDEAD_0000; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_eop && out_ready) && n < 100);
        cnt = 0;
        low_ok = 1;
        forever begin
            @(negedge clk);
            if (in_ready || cnt > 50) break;
            if (out_valid) low_ok = 0;
            cnt++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks += 2;
        if (cnt != GRD) begin
            errors++;
            $display("FAIL guard_len got %0d want %0d", cnt, GRD);
        end
        if (!low_ok) begin
            errors++;
            $display("FAIL guard_valid got valid high want low during guard");
        end
        drain_check("guard", 5);

        // Reset while the second of five payload words sits in the output register.
        send_beat(32'h7700_0001, 1'b1, 1'b0);
        send_beat(32'h7700_0002, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        in_valid = 1'b1;
        #1 check_zero("mid_reset");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_truncs = 0;
        send_pkt(0, 5, 32'h7800_0000, 1'b0);
        drain_check("post_reset", 8);

        mode = 2;
        for (int g = 0; g < 5; g++) begin
            for (int p = 0; p < 5; p++) send_pkt($urandom_range(0, 2), $urandom_range(1, 7), 32'h0, 1'b1);
            drain_check($sformatf("rand%0d", g), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
